seg_bg_compare: RTL and testbench
=================================

# seg_bg_compare

Pipelined background-difference stage of the segmentation datapath. Sits directly downstream of the segment threshold-decision logic. Per pixel it consumes:
- the current YUV sample and the matching background-model sample;
- the region-selected thresholds (BDthY/U/V, Bth, update, BckGndBuildTH).

It produces a foreground mask bit and the background-model write-back value, with a fixed 3-cycle latency and no backpressure.

## Interface
Parameters:
- PIX_W, 8, width of Y/U/V and background samples
- ALPHA_SH, 2, running-average shift (learning rate 2^-ALPHA_SH)
- CNT_W, 20, width of the per-frame foreground counter (stats feature only)

Ports:
- clk_i  in  1  single clock
- rst_n_i  in  1  reset, synchronous, active-low
- valid_i  in  1  pixel qualifier; one pixel per cycle when high
- sof_i  in  1  first pixel of frame; meaningful only with valid_i
- Y_i, U_i, V_i  in  PIX_W  current pixel
- bgY_i, bgU_i, bgV_i  in  PIX_W  background model at the same pixel, aligned with valid_i
- BDthY_i, BDthU_i, BDthV_i  in  8  per-channel difference thresholds
- Bth_i  in  8  summed-difference threshold
- update_i  in  1  allow model update on background pixels
- BckGndBuildTH_i  in  8  number of build-phase frames
- valid_o  out  1  output qualifier
- sof_o  out  1  sof_i delayed with the pixel
- fg_o  out  1  foreground mask bit
- bg_we_o  out  1  write-enable for the background memory
- bgY_o, bgU_o, bgV_o  out  PIX_W  new background value
- fg_count_o  out  CNT_W  foreground count of the previous frame (SEG_BG_STATS_EN only)
- fg_count_vld_o  out  1  one-cycle strobe when fg_count_o updates (SEG_BG_STATS_EN only)

Reset value is 0 for every output.

## Operation
- **frame_cnt** (8 b):
  - 0 at reset.
  - Increments, saturating at 255, on every accepted pixel with sof_i set.
  - The sof pixel itself uses the incremented value.
- **Build phase:** frame_cnt ≤ BckGndBuildTH_i, with BckGndBuildTH_i sampled with the pixel.
- **Init frame:** frame_cnt ≤ 1. Pixels before the first sof are also init.
- **Stage 1:**
  - dY = |Y−bgY|, same for dU and dV, in PIX_W bits.
  - Register the diffs, the pixel, the background samples, the thresholds, sof and valid.
- **Stage 2:**
  - sum = dY+dU+dV, PIX_W+2 bits, no overflow.
  - over = (dY>BDthY) | (dU>BDthU) | (dV>BDthV) | (sum>Bth), with Bth zero-extended.
  - Compute the build and init flags.
- **Stage 3:**
  - fg = over & ~build.
  - Per channel: new = bg + ((cur−bg) >>> ALPHA_SH), signed PIX_W+1 arithmetic, truncated to PIX_W. The result is always in range.
  - The floor shift means bg converges to cur from above and may stall up to 2^ALPHA_SH−1 below cur. This is accepted behaviour.
  - Init frame: new = cur.
  - bg_we = valid & (build | (update & ~fg)).
  - When bg_we = 0, bg*_o carries the unmodified bg.
- All comparisons are strict (>). Threshold 255 never flags that channel.

## Timing
- Latency: valid_i at cycle N → valid_o at N+3. Every pipeline field moves each cycle with no stall.
- Throughput: 1 pixel/clock. Gaps in valid_i propagate unchanged.
- Outputs other than valid_o hold their last value when valid_o = 0. Only bg_we_o, fg_o and fg_count_vld_o are forced 0 in that case.
- sof on back-to-back cycles is legal; frame_cnt increments each time.
- Reset mid-frame: pipeline valids, frame_cnt and stats clear on the next edge. In-flight pixels are dropped. The next frame restarts the build phase.

## Configuration
- **SEG_BG_STATS_EN defined:**
  - Counts fg_o=1 output pixels per frame, saturating at 2^CNT_W−1.
  - On an output pixel with sof_o=1: fg_count_o takes the completed count, fg_count_vld_o pulses for 1 cycle, and the counter restarts at that pixel's fg.
  - No strobe is issued for the first frame after reset.
- **Undefined:** the counter logic and both ports are absent.

## Structure
- Shared package seg_pkg holds:
  - PIX_W default and ALPHA_SH default;
  - a struct for the threshold bundle {BDthY, BDthU, BDthV, Bth, update, BckGndBuildTH};
  - a struct for the YUV triple.
- One sub-module, seg_absdiff: per-channel |a−b| plus the running-average update. Instantiated ×3.
- Pipeline registers and frame_cnt live in the top.

## Test plan
- Reset, BckGndBuildTH=2, three frames of 4 pixels, Y=100, bg=0 → frames 1–2: fg_o=0, bg_we_o=1. Frame 1: bgY_o=100. Frame 3: fg_o=1 (dY=100>BDthY=20).
- Past build, Y=120, bgY=100, BDthY=20, Bth=255, U/V equal → fg_o=0 (not strictly greater). Y=121 → fg_o=1, bg_we_o=0.
- Past build, dY=dU=dV=10, BDth*=20, Bth=29 → fg_o=1 via the sum. With Bth=30 → fg_o=0, bg_we_o=update_i, bgY_o=bg+2 (ALPHA_SH=2, cur=bg+10).
- valid_i pattern 1,0,1,1 → valid_o reproduces the same pattern 3 cycles later, bg_we_o=0 in the gaps.
- Reset asserted one cycle after a pixel enters → no valid_o for that pixel; frame_cnt=0 afterwards.
- SEG_BG_STATS_EN: frame with 5 foreground pixels followed by sof → fg_count_o=5, single-cycle fg_count_vld_o aligned with sof_o.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and defaults for the segmentation
// background-difference datapath.
package seg_pkg;

  localparam int SEG_PIX_W    = 8;
  localparam int SEG_ALPHA_SH = 2;

  typedef struct packed {
    logic [7:0] bd_y;
    logic [7:0] bd_u;
    logic [7:0] bd_v;
    logic [7:0] bth;
    logic       update;
    logic [7:0] build_th;
  } seg_th_t;

  typedef struct packed {
    logic [SEG_PIX_W-1:0] y;
    logic [SEG_PIX_W-1:0] u;
    logic [SEG_PIX_W-1:0] v;
  } seg_yuv_t;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] x
  );
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

endpackage

// File: rtl/seg_absdiff.sv
// Per-channel |cur-bg| and running-average
// background update, purely combinational.
module seg_absdiff
  import seg_pkg::*;
#(
  parameter int PIX_W    = SEG_PIX_W,
  parameter int ALPHA_SH = SEG_ALPHA_SH
) (
  input  logic [PIX_W-1:0] cur,
  input  logic [PIX_W-1:0] bg,
  output logic [PIX_W-1:0] diff,
  output logic [PIX_W-1:0] avg
);

  logic signed [PIX_W:0] delta;
  logic signed [PIX_W:0] step;
  logic signed [PIX_W:0] sum;

  // floor-shifted step toward cur, one sign bit of headroom
  always_comb begin
    delta = $signed({1'b0, cur}) - $signed({1'b0, bg});
    step  = delta >>> ALPHA_SH;
    sum   = $signed({1'b0, bg}) + step;
    avg   = PIX_W'(sum);
    diff  = (cur > bg) ? (cur - bg) : (bg - cur);
  end

endmodule

// File: rtl/seg_bg_compare.sv
// Three-stage background-difference pipeline.
// Optional foreground stats: SEG_BG_STATS_EN.
module seg_bg_compare
  import seg_pkg::*;
#(
  parameter int PIX_W    = SEG_PIX_W,
  parameter int ALPHA_SH = SEG_ALPHA_SH
`ifdef SEG_BG_STATS_EN
  ,
  parameter int CNT_W    = 20
`endif
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  input  logic             sof_i,
  input  logic [PIX_W-1:0] Y_i,
  input  logic [PIX_W-1:0] U_i,
  input  logic [PIX_W-1:0] V_i,
  input  logic [PIX_W-1:0] bgY_i,
  input  logic [PIX_W-1:0] bgU_i,
  input  logic [PIX_W-1:0] bgV_i,
  input  logic [7:0]       BDthY_i,
  input  logic [7:0]       BDthU_i,
  input  logic [7:0]       BDthV_i,
  input  logic [7:0]       Bth_i,
  input  logic             update_i,
  input  logic [7:0]       BckGndBuildTH_i,
  output logic             valid_o,
  output logic             sof_o,
  output logic             fg_o,
  output logic             bg_we_o,
  output logic [PIX_W-1:0] bgY_o,
  output logic [PIX_W-1:0] bgU_o,
  output logic [PIX_W-1:0] bgV_o
`ifdef SEG_BG_STATS_EN
  ,
  output logic [CNT_W-1:0] fg_count_o,
  output logic             fg_count_vld_o
`endif
);

  localparam int SW = PIX_W + 2;

  typedef logic [2:0][PIX_W-1:0] yuv_t;

  yuv_t       cur0, bg0, diff0, avg0;
  seg_th_t    th0;
  logic [7:0] frame_cnt, fc0;

  assign cur0 = {V_i, U_i, Y_i};
  assign bg0  = {bgV_i, bgU_i, bgY_i};
  assign th0  = '{bd_y:     BDthY_i,
                  bd_u:     BDthU_i,
                  bd_v:     BDthV_i,
                  bth:      Bth_i,
                  update:   update_i,
                  build_th: BckGndBuildTH_i};

  // the sof pixel already sees the new frame number
  assign fc0 = (valid_i && sof_i) ?
               sat_inc8(frame_cnt) : frame_cnt;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    seg_absdiff #(
      .PIX_W    (PIX_W),
      .ALPHA_SH (ALPHA_SH)
    ) u_ch (
      .cur  (cur0[c]),
      .bg   (bg0[c]),
      .diff (diff0[c]),
      .avg  (avg0[c])
    );
  end

  // frame counter, saturating
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)
      frame_cnt <= '0;
    else if (valid_i && sof_i)
      frame_cnt <= sat_inc8(frame_cnt);
  end

  logic       v1, sof1;
  logic [7:0] fc1;
  seg_th_t    th1;
  yuv_t       cur1, bg1, d1, avg1;

  // stage 1 valid
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) v1 <= 1'b0;
    else          v1 <= valid_i;
  end

  // stage 1 data, moves every cycle
  always_ff @(posedge clk_i) begin
    sof1 <= valid_i & sof_i;
    fc1  <= fc0;
    th1  <= th0;
    cur1 <= cur0;
    bg1  <= bg0;
    d1   <= diff0;
    avg1 <= avg0;
  end

  logic [SW-1:0] sum1;
  logic          over1, build1, init1;

  // threshold tests and phase flags
  always_comb begin
    sum1   = SW'(d1[0]) + SW'(d1[1]) + SW'(d1[2]);
    over1  = (SW'(d1[0]) > SW'(th1.bd_y)) |
             (SW'(d1[1]) > SW'(th1.bd_u)) |
             (SW'(d1[2]) > SW'(th1.bd_v)) |
             (sum1 > SW'(th1.bth));
    build1 = fc1 <= th1.build_th;
    init1  = fc1 <= 8'd1;
  end

  logic v2, sof2, over2, build2, init2, upd2;
  yuv_t cur2, bg2, avg2;

  // stage 2 valid
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) v2 <= 1'b0;
    else          v2 <= v1;
  end

  // stage 2 data, moves every cycle
  always_ff @(posedge clk_i) begin
    sof2   <= sof1;
    over2  <= over1;
    build2 <= build1;
    init2  <= init1;
    upd2   <= th1.update;
    cur2   <= cur1;
    bg2    <= bg1;
    avg2   <= avg1;
  end

  logic fg_n, we_n;
  yuv_t bg_n;

  // mask decision and write-back value
  always_comb begin
    fg_n = over2 & ~build2;
    we_n = build2 | (upd2 & ~fg_n);
    for (int c = 0; c < 3; c++) begin
      bg_n[c] = we_n ?
                (init2 ? cur2[c] : avg2[c]) :
                bg2[c];
    end
  end

  // output stage, holds data across gaps
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      sof_o   <= 1'b0;
      fg_o    <= 1'b0;
      bg_we_o <= 1'b0;
      bgY_o   <= '0;
      bgU_o   <= '0;
      bgV_o   <= '0;
    end else begin
      valid_o <= v2;
      if (v2) begin
        sof_o   <= sof2;
        fg_o    <= fg_n;
        bg_we_o <= we_n;
        bgY_o   <= bg_n[0];
        bgU_o   <= bg_n[1];
        bgV_o   <= bg_n[2];
      end else begin
        fg_o    <= 1'b0;
        bg_we_o <= 1'b0;
      end
    end
  end

`ifdef SEG_BG_STATS_EN
  logic [CNT_W-1:0] fg_cnt;
  logic             frame_seen;

  // per-frame foreground count, reported at next sof
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      fg_cnt         <= '0;
      frame_seen     <= 1'b0;
      fg_count_o     <= '0;
      fg_count_vld_o <= 1'b0;
    end else begin
      fg_count_vld_o <= 1'b0;
      if (v2) begin
        if (sof2) begin
          if (frame_seen) begin
            fg_count_o     <= fg_cnt;
            fg_count_vld_o <= 1'b1;
          end
          fg_cnt     <= CNT_W'(fg_n);
          frame_seen <= 1'b1;
        end else if (fg_n && fg_cnt != '1) begin
          fg_cnt <= fg_cnt + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_seg_bg_compare.sv
// Directed scoreboard bench for seg_bg_compare.
// Stats checks compile in with SEG_BG_STATS_EN.
module tb_seg_bg_compare;
  import seg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n_i, valid_i, sof_i;
  logic [7:0] Y_i, U_i, V_i, bgY_i, bgU_i, bgV_i;
  logic [7:0] BDthY_i, BDthU_i, BDthV_i, Bth_i;
  logic       update_i;
  logic [7:0] BckGndBuildTH_i;
  logic       valid_o, sof_o, fg_o, bg_we_o;
  logic [7:0] bgY_o, bgU_o, bgV_o;
`ifdef SEG_BG_STATS_EN
  localparam int CNT_W = 20;
  logic [CNT_W-1:0] fg_count_o;
  logic             fg_count_vld_o;
  int               m_cnt;
  bit               m_started;
`endif

  always #5 clk = ~clk;

  seg_bg_compare dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n_i),
    .valid_i         (valid_i),
    .sof_i           (sof_i),
    .Y_i             (Y_i),
    .U_i             (U_i),
    .V_i             (V_i),
    .bgY_i           (bgY_i),
    .bgU_i           (bgU_i),
    .bgV_i           (bgV_i),
    .BDthY_i         (BDthY_i),
    .BDthU_i         (BDthU_i),
    .BDthV_i         (BDthV_i),
    .Bth_i           (Bth_i),
    .update_i        (update_i),
    .BckGndBuildTH_i (BckGndBuildTH_i),
    .valid_o         (valid_o),
    .sof_o           (sof_o),
    .fg_o            (fg_o),
    .bg_we_o         (bg_we_o),
    .bgY_o           (bgY_o),
    .bgU_o           (bgU_o),
    .bgV_o           (bgV_o)
`ifdef SEG_BG_STATS_EN
    ,
    .fg_count_o      (fg_count_o),
    .fg_count_vld_o  (fg_count_vld_o)
`endif
  );

  typedef struct {
    int       stamp;
    logic     sof;
    logic     fg;
    logic     we;
    seg_yuv_t bg;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mfc = 0;
  bit   mon_en = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int avg_ref(input int c,
                                 input int b);
    int d, s, stp;
    d = c - b;
    s = 1 << SEG_ALPHA_SH;
    if (d >= 0) stp = d / s;
    else        stp = -((-d + s - 1) / s);
    return b + stp;
  endfunction

  function automatic int adiff(input int a,
                               input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic pix(input logic sof,
                     input int y, input int u,
                     input int v, input int by,
                     input int bu, input int bv);
    int  dy, du, dv;
    bit  over, build, init;
    exp_t x;
    valid_i = 1'b1;
    sof_i   = sof;
    Y_i = 8'(y);   U_i = 8'(u);   V_i = 8'(v);
    bgY_i = 8'(by); bgU_i = 8'(bu); bgV_i = 8'(bv);
    if (sof && mfc < 255) mfc++;
    dy = adiff(y, by);
    du = adiff(u, bu);
    dv = adiff(v, bv);
    over = (dy > int'(BDthY_i)) ||
           (du > int'(BDthU_i)) ||
           (dv > int'(BDthV_i)) ||
           (dy + du + dv > int'(Bth_i));
    build = mfc <= int'(BckGndBuildTH_i);
    init  = mfc <= 1;
    x.stamp = cyc;
    x.sof   = sof;
    x.fg    = over && !build;
    x.we    = build || (update_i && !x.fg);
    x.bg.y = 8'(!x.we ? by : init ? y : avg_ref(y, by));
    x.bg.u = 8'(!x.we ? bu : init ? u : avg_ref(u, bu));
    x.bg.v = 8'(!x.we ? bv : init ? v : avg_ref(v, bv));
    q.push_back(x);
    tick();
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    sof_i   = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    sof_i   = 1'b0;
    q.delete();
    mfc = 0;
`ifdef SEG_BG_STATS_EN
    m_cnt = 0;
    m_started = 0;
`endif
    tick();
    tick();
    check("rst_valid", valid_o, 0);
    check("rst_sof", sof_o, 0);
    check("rst_fg", fg_o, 0);
    check("rst_we", bg_we_o, 0);
    check("rst_bgY", bgY_o, 0);
    check("rst_bgU", bgU_o, 0);
    check("rst_bgV", bgV_o, 0);
    check("rst_frame_cnt", dut.frame_cnt, 0);
`ifdef SEG_BG_STATS_EN
    check("rst_cnt", fg_count_o, 0);
    check("rst_cnt_vld", fg_count_vld_o, 0);
`endif
    rst_n_i = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_o === 1'b1) begin
        checks++;
        assert (q.size() > 0) else begin
          errors++;
          $error("FAIL spurious_valid: observed 1 expected 0");
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          check("latency", cyc, e.stamp + 3);
          check("sof_o", sof_o, e.sof);
          check("fg_o", fg_o, e.fg);
          check("bg_we_o", bg_we_o, e.we);
          check("bgY_o", bgY_o, e.bg.y);
          check("bgU_o", bgU_o, e.bg.u);
          check("bgV_o", bgV_o, e.bg.v);
`ifdef SEG_BG_STATS_EN
          if (e.sof) begin
            check("cnt_vld", fg_count_vld_o,
                  m_started);
            if (m_started)
              check("fg_count", fg_count_o, m_cnt);
            m_cnt = int'(e.fg);
            m_started = 1;
          end else begin
            check("cnt_vld_mid", fg_count_vld_o, 0);
            if (e.fg && m_cnt < (1 << CNT_W) - 1)
              m_cnt++;
          end
`endif
        end
      end else begin
        check("gap_valid", valid_o, 0);
        check("gap_fg", fg_o, 0);
        check("gap_we", bg_we_o, 0);
`ifdef SEG_BG_STATS_EN
        check("gap_cnt_vld", fg_count_vld_o, 0);
`endif
      end
    end
  end

  initial begin
    int w;
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    sof_i   = 1'b0;
    Y_i = 0; U_i = 0; V_i = 0;
    bgY_i = 0; bgU_i = 0; bgV_i = 0;
    BDthY_i = 8'd20; BDthU_i = 8'd20;
    BDthV_i = 8'd20; Bth_i = 8'd255;
    update_i = 1'b1;
    BckGndBuildTH_i = 8'd2;
    do_reset();
    mon_en = 1;

    for (int f = 0; f < 3; f++)
      for (int p = 0; p < 4; p++)
        pix(p == 0, 100, 0, 0, 0, 0, 0);

    pix(1, 120, 50, 50, 100, 50, 50);
    pix(0, 121, 50, 50, 100, 50, 50);

    Bth_i = 8'd29;
    pix(0, 110, 60, 70, 100, 50, 60);
    Bth_i = 8'd30;
    pix(0, 110, 60, 70, 100, 50, 60);
    update_i = 1'b0;
    pix(0, 110, 60, 70, 100, 50, 60);
    update_i = 1'b1;

    BDthY_i = 8'd255; BDthU_i = 8'd255;
    BDthV_i = 8'd255; Bth_i = 8'd255;
    pix(0, 255, 0, 0, 0, 0, 0);
    pix(0, 0, 0, 0, 255, 0, 0);
    BDthY_i = 8'd20; BDthU_i = 8'd20;
    BDthV_i = 8'd20;

    pix(0, 30, 0, 0, 0, 0, 0);
    idle(1);
    pix(0, 31, 0, 0, 0, 0, 0);
    pix(0, 10, 0, 0, 0, 0, 0);
    idle(4);

    BckGndBuildTH_i = 8'd6;
    pix(1, 100, 0, 0, 0, 0, 0);
    pix(1, 100, 0, 0, 0, 0, 0);
    pix(1, 100, 0, 0, 0, 0, 0);
    idle(4);

    pix(1, 90, 0, 0, 0, 0, 0);
    do_reset();

    BckGndBuildTH_i = 8'd1;
    pix(1, 100, 0, 0, 0, 0, 0);
    pix(1, 100, 0, 0, 0, 0, 0);

    BckGndBuildTH_i = 8'd0;
    pix(1, 100, 0, 0, 0, 0, 0);
    for (int p = 0; p < 4; p++)
      pix(0, 80, 0, 0, 0, 0, 0);
    pix(0, 0, 0, 0, 0, 0, 0);
    pix(1, 100, 0, 0, 0, 0, 0);
    pix(0, 7, 0, 0, 7, 0, 0);
    idle(2);

    w = 0;
    while (q.size() > 0 && w < 20) begin
      tick();
      w++;
    end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed %0d pending expected 0",
             q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
